mlp_xcel_systolic_act_feeder: RTL and testbench

MLP_XCEL_SYSTOLIC_ACT_FEEDER -- requirements
Module: mlp_xcel_systolic_act_feeder

---
 rtl/mlp_xcel_systolic_act_feeder_if.sv | 13 +
 rtl/mlp_xcel_systolic_act_feeder.sv | 111 +++++++++++
 tb/tb_mlp_xcel_systolic_act_feeder.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mlp_xcel_systolic_act_feeder_if.sv
// Activation-vector stream into the systolic feeder.
// The producer drives in_val/in_act; the feeder answers with in_rdy.
interface mlp_xcel_systolic_act_feeder_if #(
  parameter int N = 4,
  parameter int W = 32
);
  logic           in_val;
  logic           in_rdy;
  logic [N*W-1:0] in_act;

  modport master (output in_val, output in_act, input in_rdy);
  modport slave  (input in_val, input in_act, output in_rdy);
endinterface

// File: rtl/mlp_xcel_systolic_act_feeder.sv
// Skewing activation feeder for an N-row systolic array: row i is delayed by i+1
// advancing cycles, and bubbles are inserted as zero data with a cleared valid bit.
module mlp_xcel_systolic_act_feeder #(
  parameter int N = 4,
  parameter int W = 32
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic                                 start,
  input  logic [15:0]                          len,
  mlp_xcel_systolic_act_feeder_if.slave        in_s,
  input  logic                                 adv,
  output logic [N*W-1:0]                       act_out,
  output logic [N-1:0]                         act_vld,
  output logic                                 busy,
  output logic                                 done
);
  localparam int CW = $clog2(N);

  // state | meaning
  // IDLE  | no job; waits for start
  // FEED  | accepting vectors until the job count is used up
  // DRAIN | waits for the last vector to reach row N-1 at the outputs
  typedef enum logic [1:0] {IDLE, FEED, DRAIN} state_t;

  state_t        state, state_nxt;
  logic [15:0]   remaining;
  logic [CW-1:0] drain_cnt;
  logic          rdy;
  logic          accept;
  logic          last_accept;
  logic          drain_end;

  assign accept      = in_s.in_val && rdy;
  assign last_accept = accept && (remaining == 16'd1);
  assign drain_end   = adv && (state == DRAIN) && (drain_cnt == CW'(1));
  assign in_s.in_rdy = rdy;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (adv && start) state_nxt = FEED;
      FEED:    if (last_accept)  state_nxt = DRAIN;
      DRAIN:   if (drain_end)    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rdy  = (state == FEED) && adv;
    busy = (state != IDLE);
  end

  // done is sampled every edge so it stays a single-cycle pulse even while stalled
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      remaining <= '0;
      drain_cnt <= '0;
      done      <= 1'b0;
    end else begin
      done <= drain_end;
      if (adv) begin
        case (state)
          IDLE: begin
            if (start) remaining <= (len == 16'd0) ? 16'd1 : len;
          end
          FEED: begin
            if (accept) begin
              remaining <= remaining - 16'd1;
              if (remaining == 16'd1) drain_cnt <= CW'(N - 1);
            end
          end
          DRAIN: begin
            drain_cnt <= drain_cnt - CW'(1);
          end
          default: begin
            remaining <= '0;
            drain_cnt <= '0;
          end
        endcase
      end
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_row
    logic [i:0][W-1:0] dat;
    logic [i:0]        vld;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        dat <= '0;
        vld <= '0;
      end else if (adv) begin
        dat[0] <= accept ? in_s.in_act[i*W +: W] : '0;
        vld[0] <= accept;
        for (int j = 1; j <= i; j++) begin
          dat[j] <= dat[j-1];
          vld[j] <= vld[j-1];
        end
      end
    end

    assign act_out[i*W +: W] = dat[i];
    assign act_vld[i]        = vld[i];
  end
endmodule

// File: tb/tb_mlp_xcel_systolic_act_feeder.sv
// Bench for the systolic activation feeder: directed table, hand sequences and
// randomized traffic compared against a history-based reference model.
module tb_mlp_xcel_systolic_act_feeder;
  localparam int N  = 4;
  localparam int W  = 32;
  localparam int NW = N * W;

  logic           clk = 1'b0;
  logic           reset_n;
  logic           start;
  logic [15:0]    len;
  logic           adv;
  logic [NW-1:0]  act_out;
  logic [N-1:0]   act_vld;
  logic           busy;
  logic           done;

  mlp_xcel_systolic_act_feeder_if #(.N(N), .W(W)) in_if ();

  mlp_xcel_systolic_act_feeder #(.N(N), .W(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .len     (len),
    .in_s    (in_if.slave),
    .adv     (adv),
    .act_out (act_out),
    .act_vld (act_vld),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  int last_acc_cyc = -100;
  int last_done_cyc = -100;

  // Reference model: one history slot per advancing edge; row i shows the slot
  // pushed i advancing edges ago. Job completion is an absolute edge number.
  logic [NW:0] hist[$];
  bit          m_active;
  int          m_left;
  longint      m_edges;
  longint      m_done_at;
  bit          m_done;

  typedef struct {
    logic          st;
    logic [15:0]   ln;
    logic          iv;
    logic [NW-1:0] ia;
    logic          ad;
    logic          rdy;
    logic          bsy;
    logic          dn;
    logic [N-1:0]  vld;
    logic [NW-1:0] out;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [NW-1:0] got, input logic [NW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic void model_reset();
    hist.delete();
    m_active  = 1'b0;
    m_left    = 0;
    m_edges   = 0;
    m_done_at = -1;
    m_done    = 1'b0;
  endfunction

  function automatic void model_outputs(output logic [NW-1:0] o, output logic [N-1:0] v);
    logic [NW:0] slot;
    o = '0;
    v = '0;
    for (int i = 0; i < N; i++) begin
      if (hist.size() > i) begin
        slot = hist[hist.size() - 1 - i];
        o[i*W +: W] = slot[i*W +: W];
        v[i] = slot[NW];
      end
    end
  endfunction

  // Called right after a falling edge; returns the in_rdy seen during the cycle.
  task automatic cycle(input logic st, input logic [15:0] ln, input logic iv,
                       input logic [NW-1:0] ia, input logic ad, output logic rdy_seen);
    bit            exp_rdy;
    bit            acc;
    logic [NW-1:0] eo;
    logic [N-1:0]  ev;
    start        = st;
    len          = ln;
    in_if.in_val = iv;
    in_if.in_act = ia;
    adv          = ad;
    #1;
    rdy_seen = in_if.in_rdy;
    exp_rdy  = m_active && (m_left > 0) && ad;
    chk("in_rdy", NW'(in_if.in_rdy), NW'(exp_rdy));
    acc = exp_rdy && iv;
    if (rdy_seen && iv) last_acc_cyc = cyc;
    @(posedge clk);
    m_done = 1'b0;
    if (ad) begin
      m_edges++;
      if (acc) begin
        hist.push_back({1'b1, ia});
        m_left--;
        if (m_left == 0) m_done_at = m_edges + N - 1;
      end else begin
        hist.push_back('0);
      end
      if (hist.size() > N) void'(hist.pop_front());
      if (!m_active && st) begin
        m_active = 1'b1;
        m_left   = (ln == 16'd0) ? 1 : int'(ln);
      end else if (m_active && m_left == 0 && m_edges == m_done_at) begin
        m_active = 1'b0;
        m_done   = 1'b1;
      end
    end
    @(negedge clk);
    model_outputs(eo, ev);
    chk("act_out", act_out, eo);
    chk("act_vld", NW'(act_vld), NW'(ev));
    chk("busy", NW'(busy), NW'(m_active));
    chk("done", NW'(done), NW'(m_done));
    if (done) last_done_cyc = cyc;
    cyc++;
  endtask

  task automatic cyc_s(input logic st, input logic [15:0] ln, input logic iv,
                       input logic [NW-1:0] ia, input logic ad);
    logic r;
    cycle(st, ln, iv, ia, ad, r);
  endtask

  function automatic vec_t mk(input logic st, input logic [15:0] ln, input logic iv,
                              input logic [NW-1:0] ia, input logic rdy, input logic bsy,
                              input logic dn, input logic [N-1:0] vld, input logic [NW-1:0] out);
    vec_t v;
    v.st = st; v.ln = ln; v.iv = iv; v.ia = ia; v.ad = 1'b1;
    v.rdy = rdy; v.bsy = bsy; v.dn = dn; v.vld = vld; v.out = out;
    return v;
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_act_out"}, act_out, '0);
    chk({tag, "_act_vld"}, NW'(act_vld), '0);
    chk({tag, "_busy"}, NW'(busy), '0);
    chk({tag, "_done"}, NW'(done), '0);
    chk({tag, "_in_rdy"}, NW'(in_if.in_rdy), '0);
  endtask

  initial begin
    logic [NW-1:0] va, vb, v0, v1, v2, snap_o, ia;
    logic [N-1:0]  snap_v;
    logic          r, st, iv, ad;
    logic [15:0]   ln;
    int            rdy_cnt;

    va = 128'h000000A3_000000A2_000000A1_000000A0;
    vb = 128'h000000B3_000000B2_000000B1_000000B0;

    // skew, bubbles, ignored start while draining, start in the done cycle, len=0, in_val in IDLE
    tbl.push_back(mk(1, 16'd1, 0, '0, 0, 1, 0, 4'b0000, '0));
    tbl.push_back(mk(0, 16'd0, 1, va, 1, 1, 0, 4'b0001, 128'h00000000_00000000_00000000_000000A0));
    tbl.push_back(mk(1, 16'd9, 0, '0, 0, 1, 0, 4'b0010, 128'h00000000_00000000_000000A1_00000000));
    tbl.push_back(mk(0, 16'd0, 0, '0, 0, 1, 0, 4'b0100, 128'h00000000_000000A2_00000000_00000000));
    tbl.push_back(mk(0, 16'd0, 0, '0, 0, 0, 1, 4'b1000, 128'h000000A3_00000000_00000000_00000000));
    tbl.push_back(mk(1, 16'd0, 0, '0, 0, 1, 0, 4'b0000, '0));
    tbl.push_back(mk(0, 16'd0, 1, vb, 1, 1, 0, 4'b0001, 128'h00000000_00000000_00000000_000000B0));
    tbl.push_back(mk(0, 16'd0, 0, '0, 0, 1, 0, 4'b0010, 128'h00000000_00000000_000000B1_00000000));
    tbl.push_back(mk(0, 16'd0, 0, '0, 0, 1, 0, 4'b0100, 128'h00000000_000000B2_00000000_00000000));
    tbl.push_back(mk(0, 16'd0, 0, '0, 0, 0, 1, 4'b1000, 128'h000000B3_00000000_00000000_00000000));
    tbl.push_back(mk(0, 16'd0, 1, va, 0, 0, 0, 4'b0000, '0));

    start = 1'b0; len = '0; adv = 1'b1;
    in_if.in_val = 1'b0; in_if.in_act = '0;
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    #1 check_reset_outputs("init_rst");
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    for (int k = 0; k < tbl.size(); k++) begin
      cycle(tbl[k].st, tbl[k].ln, tbl[k].iv, tbl[k].ia, tbl[k].ad, r);
      chk($sformatf("tbl%0d_in_rdy", k), NW'(r), NW'(tbl[k].rdy));
      chk($sformatf("tbl%0d_busy", k), NW'(busy), NW'(tbl[k].bsy));
      chk($sformatf("tbl%0d_done", k), NW'(done), NW'(tbl[k].dn));
      chk($sformatf("tbl%0d_act_vld", k), NW'(act_vld), NW'(tbl[k].vld));
      chk($sformatf("tbl%0d_act_out", k), act_out, tbl[k].out);
    end

    // streaming len=3 with in_val held high and a len=9 start mid-feed
    v0 = 128'h10000003_10000002_10000001_10000000;
    v1 = 128'h20000003_20000002_20000001_20000000;
    v2 = 128'h30000003_30000002_30000001_30000000;
    rdy_cnt = 0;
    last_done_cyc = -100;
    cycle(1, 16'd3, 1, v0, 1, r); rdy_cnt += int'(r);
    cycle(0, 16'd0, 1, v0, 1, r); rdy_cnt += int'(r);
    cycle(1, 16'd9, 1, v1, 1, r); rdy_cnt += int'(r);
    cycle(0, 16'd0, 1, v2, 1, r); rdy_cnt += int'(r);
    for (int k = 0; k < 5; k++) begin
      cycle(0, 16'd0, 1, v2, 1, r);
      rdy_cnt += int'(r);
    end
    chk("stream_rdy_cnt", NW'(rdy_cnt), NW'(3));
    chk("stream_done_lat", NW'(last_done_cyc - last_acc_cyc), NW'(N - 1));

    // bubble between vectors, then a two-cycle stall mid-drain
    last_done_cyc = -100;
    cyc_s(1, 16'd2, 0, '0, 1);
    cyc_s(0, 16'd0, 1, v0, 1);
    cyc_s(0, 16'd0, 0, v2, 1);
    cyc_s(0, 16'd0, 1, v1, 1);
    cyc_s(0, 16'd0, 0, '0, 1);
    snap_o = act_out;
    snap_v = act_vld;
    for (int k = 0; k < 2; k++) begin
      cyc_s(0, 16'd0, 1, v2, 0);
      chk("stall_frozen_out", act_out, snap_o);
      chk("stall_frozen_vld", NW'(act_vld), NW'(snap_v));
    end
    for (int k = 0; k < 3; k++) cyc_s(0, 16'd0, 0, '0, 1);
    chk("stall_done_lat", NW'(last_done_cyc - last_acc_cyc), NW'(N + 1));

    // asynchronous reset while draining, then a fresh job
    cyc_s(1, 16'd2, 0, '0, 1);
    cyc_s(0, 16'd0, 1, v0, 1);
    cyc_s(0, 16'd0, 1, v1, 1);
    cyc_s(0, 16'd0, 0, '0, 1);
    #2 reset_n = 1'b0;
    #1 check_reset_outputs("mid_rst");
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    last_done_cyc = -100;
    cyc_s(1, 16'd1, 0, '0, 1);
    cyc_s(0, 16'd0, 1, vb, 1);
    for (int k = 0; k < N; k++) cyc_s(0, 16'd0, 0, '0, 1);
    chk("post_rst_done_lat", NW'(last_done_cyc - last_acc_cyc), NW'(N - 1));

    // randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      st = ($urandom_range(0, 7) == 0);
      ln = 16'($urandom_range(0, 5));
      iv = ($urandom_range(0, 9) < 7);
      ad = ($urandom_range(0, 9) < 8);
      for (int j = 0; j < N; j++) ia[j*W +: W] = $urandom;
      cyc_s(st, ln, iv, ia, ad);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
